// File: rtl/tm_stream_pkg.sv
// tm_stream_pkg: shared types and constants for the tone-mapping stream buffer.
package tm_stream_pkg;
    localparam int PIX_W   = 8;
    localparam int ENTRY_W = 3*PIX_W+2;
    localparam int CNT_W   = 16;
    typedef enum logic [1:0] {WAIT_SOP, PASS, DROP} state_t;
    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } entry_t;
endpackage

// File: rtl/tm_sfifo_ram.sv
// tm_sfifo_ram: simple dual-port RAM with registered, read-before-write output.
module tm_sfifo_ram #(
    parameter int DW    = 26,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    always_ff @(posedge clk)
        if (!reset_n) rdata <= '0;
        else rdata <= mem[raddr];
endmodule

// File: rtl/tm_stream_buffer.sv
// tm_stream_buffer: frame-aware FWFT FIFO between the tone-mapper and a valid/ready sink.
// Overflow truncates the current frame and resynchronises on the next sop.
module tm_stream_buffer
    import tm_stream_pkg::*;
#(
    parameter int W     = PIX_W,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sop_i,
    input  logic             eop_i,
    input  logic             valid_i,
    input  logic [W-1:0]     data_r_i,
    input  logic [W-1:0]     data_g_i,
    input  logic [W-1:0]     data_b_i,
    input  logic             ready_i,
    output logic [3*W-1:0]   data_o,
    output logic             sop_o,
    output logic             eop_o,
    output logic             valid_o,
    output logic [AW:0]      fill_o,
    output logic             overflow_o,
    output logic             err_sop_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    input  logic             clr_stat_i
);
    localparam int EW = 3*W+2;
    state_t state, state_n;
    logic [AW-1:0] wr_ptr, rd_ptr, raddr;
    logic [AW:0] fill;
    logic [EW-1:0] head;
    logic [CNT_W-1:0] drop_cnt;
    logic full, wr, rd, ovf_n, err_n, inc, in_frame;
    assign full  = fill == (AW+1)'(DEPTH);
    assign rd    = valid_o & ready_i;
    assign raddr = rd_ptr + AW'(rd);
    always_comb begin
        state_n = state;
        wr      = 1'b0;
        ovf_n   = 1'b0;
        err_n   = 1'b0;
        inc     = 1'b0;
        case (state)
            PASS: if (valid_i) begin
                if (full) begin
                    ovf_n   = 1'b1;
                    inc     = 1'b1;
                    state_n = DROP;
                end else begin
                    wr    = 1'b1;
                    err_n = sop_i & in_frame;
                end
            end
            default: if (valid_i && sop_i && !full) begin
                wr      = 1'b1;
                state_n = PASS;
            end
        endcase
    end
    // valid_o tracks entries already in RAM before this edge, giving the one-cycle write-to-read latency
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= WAIT_SOP;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
            err_sop_o  <= 1'b0;
            in_frame   <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr + AW'(wr);
            rd_ptr     <= raddr;
            fill       <= fill + (AW+1)'(wr) - (AW+1)'(rd);
            valid_o    <= (fill - (AW+1)'(rd)) != '0;
            overflow_o <= ovf_n;
            err_sop_o  <= err_n;
            in_frame   <= wr ? !eop_i : in_frame;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) drop_cnt <= '0;
        else if (clr_stat_i) drop_cnt <= CNT_W'(inc);
        else if (inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
    tm_sfifo_ram #(.DW(EW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr),
        .waddr   (wr_ptr),
        .wdata   ({sop_i, eop_i, data_r_i, data_g_i, data_b_i}),
        .raddr   (raddr),
        .rdata   (head)
    );
    assign sop_o      = head[EW-1];
    assign eop_o      = head[EW-2];
    assign data_o     = head[3*W-1:0];
    assign fill_o     = fill;
    assign drop_cnt_o = drop_cnt;
endmodule

// File: doc/tm_stream_buffer.md
Name: tm_stream_buffer

Overview:
- Downstream neighbour of the tone-mapping wrapper. Consumes its 8-bit/channel RGB stream (sop/eop/valid, no backpressure) and buffers it in a synchronous FIFO.
- Presents the buffered stream to the video output / DMA side with a valid/ready handshake.
- On overflow it discards the remainder of the current frame and resynchronises on the next sop, so downstream only ever sees whole frames or a clean truncation.
- Provides drop and protocol-error statistics for the register map.

Parameters:
- W, 8, per-channel pixel width (matches the tone-mapping output width).
- DEPTH, 64, FIFO entries; must be a power of 2, at least 4.
- AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- sop_i  in  1  start of frame, qualified by valid_i.
- eop_i  in  1  end of frame, qualified by valid_i.
- valid_i  in  1  input beat strobe.
- data_r_i / data_g_i / data_b_i  in  W each  pixel channels.
- ready_i  in  1  downstream accepts a beat.
- data_o  out  3*W  {r,g,b}, with r in the MSBs.
- sop_o / eop_o  out  1 each  frame markers aligned to data_o.
- valid_o  out  1  output beat available.
- fill_o  out  AW+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  one-cycle pulse per discarded beat while in PASS.
- err_sop_o  out  1  one-cycle pulse when sop_i arrives mid-frame in PASS.
- drop_cnt_o  out  16  count of frames truncated; saturating.
- clr_stat_i  in  1  synchronous clear of drop_cnt_o.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Pointers and fill go to 0; valid_o=0.
  - sop_o, eop_o, overflow_o and err_sop_o go to 0; data_o goes to 0.
  - drop_cnt_o goes to 0; state goes to WAIT_SOP.
  - A reset mid-frame flushes the FIFO, and the partial frame is lost.
- FIFO entry format: {sop, eop, r, g, b}.
- Write rule: write=valid_i and (accepting state) and not full. full is evaluated on the pre-read occupancy, so a read in the same cycle does not free space for that cycle's write.
- Read rule: read=valid_o and ready_i.
  - First-word fall-through: valid_o=(fill!=0).
  - data_o, sop_o and eop_o show the head entry whenever valid_o=1, and hold stable while ready_i=0.
  - Latency: a beat written at edge N is visible on the outputs after edge N+1.
- Simultaneous read and write: fill is unchanged.
- Pointers wrap modulo DEPTH.
- A beat with sop and eop both set (single-beat frame) is legal.
- State machine:
  - WAIT_SOP: discard beats without sop. On valid_i&sop_i&!full, write the beat and go to PASS. If full, discard it and stay; no count.
  - PASS, on valid_i:
    - If full: discard the beat, pulse overflow_o, increment drop_cnt, go to DROP.
    - Else if sop_i: write the beat, pulse err_sop_o, stay in PASS (new frame starts).
    - Else: write the beat. If eop_i is set, stay in PASS, ready for the next frame.
  - DROP: discard all beats until valid_i&sop_i&!full. That beat is written and the state goes to PASS. No further overflow pulses or counts are generated in DROP.
- drop_cnt_o rules:
  - Saturates at 16'hFFFF.
  - clr_stat_i has priority. If clr_stat_i coincides with an increment event, the result is 1.
- Status pulses are registered, asserted the cycle after the causing input beat.
- The block does not synthesise an eop for truncated frames; downstream detects truncation by a sop arriving without a preceding eop.

Decomposition:
- Package tm_stream_pkg holds:
  - the state enum (WAIT_SOP, PASS, DROP);
  - the packed struct for the FIFO entry, parameterised via localparam ENTRY_W=3*W+2;
  - localparam CNT_W=16.
- One sub-module, tm_sfifo_ram: simple dual-port RAM, DEPTH x ENTRY_W, registered read.
  - The top-level holds the pointers, fill counter, FWFT output register, FSM and statistics.

Test Plan:
- Reset, then a frame of 10 beats (sop on beat 0, eop on beat 9) with ready_i=1 → 10 output beats in order, first valid_o 2 cycles after the first valid_i, drop_cnt_o=0.
- Beats without sop after reset, then a sop frame → leading beats discarded; output starts exactly at the sop beat.
- DEPTH=64, ready_i=0, 70-beat frame → fill_o=64; one overflow_o pulse on beat 65; drop_cnt_o=1; beats 65..70 absent. Then ready_i=1 and a new 5-beat frame → 64 old beats drain, then the 5 new beats.
- ready_i toggled 1/0 every cycle during a 20-beat frame → no loss, data_o/sop_o/eop_o stable during stalls, fill_o never exceeds 11.
- Sop mid-frame in PASS → err_sop_o pulses once and the beat is written; a single-beat frame with sop=eop=1 passes intact.
- drop_cnt_o forced to FFFF via repeated overflows stays at FFFF; clr_stat_i coinciding with an overflow gives drop_cnt_o=1; reset_n asserted mid-frame gives fill_o=0 and valid_o=0 next cycle, and state WAIT_SOP.
